// File: rtl/frame_transpose_buffer.sv
// frame_transpose_buffer: NUM_BUFS-slot frame store. Pixels arrive row-major and leave row- or column-major.
// Latency: the first pixel is valid about 3 cycles after the completing write. Read issues are at least RD_INTERVAL apart.
// Backpressure: the input cannot be stalled, so when every slot is full a completed frame is dropped and overflow pulses.
//   The output holds its data, sof and eof while out_valid && !out_ready.
// Optional: define FRAME_TAG_EN to replace the first pixel of each read frame with an 8-bit read-frame counter.
module frame_transpose_buffer #(
  parameter int WIDTH       = 120,
  parameter int HEIGHT      = 240,
  parameter int WR_HEIGHT   = 240,
  parameter int DATA_W      = 21,
  parameter int NUM_BUFS    = 2,
  parameter int RD_INTERVAL = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  input  logic                      transpose,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sof,
  output logic                      out_eof,
  output logic                      overflow,
  output logic [$clog2(NUM_BUFS):0] frames_pending
);

  localparam int FRAME   = WIDTH * HEIGHT;
  localparam int BEGIN_A = WIDTH * ((HEIGHT - WR_HEIGHT) / 2);
  localparam int END_A   = BEGIN_A + WIDTH * WR_HEIGHT;
  localparam int AW      = $clog2(NUM_BUFS * FRAME);
  localparam int LW      = $clog2(FRAME);
  localparam int BW      = $clog2(NUM_BUFS);
  localparam int PW      = $clog2(NUM_BUFS) + 1;
  localparam int IW      = $clog2(RD_INTERVAL);
  localparam int RW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [LW-1:0] L_BEGIN   = LW'(BEGIN_A);
  localparam logic [LW-1:0] L_WR_LAST = LW'(END_A - 1);
  localparam logic [LW-1:0] L_LAST    = LW'(FRAME - 1);
  localparam logic [LW-1:0] L_STEP    = LW'(WIDTH);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [BW-1:0] BUF_LAST  = BW'(NUM_BUFS - 1);
  localparam logic [PW-1:0] PEND_LIM  = PW'(NUM_BUFS - 1);
  localparam logic [IW-1:0] IVL_LAST  = IW'(RD_INTERVAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // Frame store. It is never reset, so rows outside the written band keep stale contents.
  logic [DATA_W-1:0] r_mem [NUM_BUFS*FRAME];

  logic [LW-1:0]     r_wr_ptr;
  logic [BW-1:0]     r_wr_buf;
  logic [PW-1:0]     r_pend;
  logic              r_overflow;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [LW-1:0]     r_rd_ptr;
  logic [RW-1:0]     r_rd_row;
  logic [CW-1:0]     r_rd_col;
  logic [BW-1:0]     r_rd_buf;
  logic              r_rd_tr;
  logic [IW-1:0]     r_ivl;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_sof;
  logic              r_out_eof;

  logic              w_wr_done;
  logic              w_wr_take;
  logic              w_drop;
  logic              w_start;
  logic              w_issue;
  logic              w_rd_done;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr;
  logic [DATA_W-1:0] w_rd_pix;

  assign w_wr_addr = AW'(r_wr_buf) * AW'(FRAME) + AW'(r_wr_ptr);
  assign w_rd_addr = AW'(r_rd_buf) * AW'(FRAME) + AW'(r_rd_ptr);

  // A read that completes in the same cycle frees its slot, so that write completion is accepted.
  assign w_wr_done = in_valid && (r_wr_ptr == L_WR_LAST);
  assign w_wr_take = w_wr_done && ((r_pend < PEND_LIM) || w_rd_done);
  assign w_drop    = w_wr_done && !w_wr_take;

  // Write incoming pixels into the current write slot. Writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (in_valid && !reset) r_mem[w_wr_addr] <= in_data;
  end

  // Write pointer and slot. A dropped frame leaves the slot unchanged, so the next frame overwrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= L_BEGIN;
      r_wr_buf <= '0;
    end else if (in_valid) begin
      r_wr_ptr <= w_wr_done ? L_BEGIN : r_wr_ptr + 1'b1;
      if (w_wr_take) r_wr_buf <= (r_wr_buf == BUF_LAST) ? '0 : r_wr_buf + 1'b1;
    end
  end

  // Pending-frame count and the registered one-cycle overflow pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      if (w_wr_take && !w_rd_done)      r_pend <= r_pend + 1'b1;
      else if (!w_wr_take && w_rd_done) r_pend <= r_pend - 1'b1;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Read FSM next state and issue decision.
  // The BRAM read lands in the output register one cycle after issue,
  // so no read is ever still in flight when the next issue is considered.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_issue     = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend != '0) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if ((r_ivl >= IVL_LAST) && (!r_out_valid || out_ready)) begin
          w_issue = 1'b1;
          if (r_rd_ptr == L_LAST) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_out_valid && out_ready) begin
          w_rd_done   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Issue interval counter. It saturates at RD_INTERVAL-1 and clears on each issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_ivl <= '0;
    else if (w_issue)           r_ivl <= '0;
    else if (r_ivl != IVL_LAST) r_ivl <= r_ivl + 1'b1;
  end

  // Read address walk. Transposed mode walks down each column, then moves to the top of the next column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_rd_row <= '0;
      r_rd_col <= '0;
      r_rd_tr  <= 1'b0;
      r_rd_buf <= '0;
    end else begin
      if (w_start) begin
        r_rd_ptr <= '0;
        r_rd_row <= '0;
        r_rd_col <= '0;
        r_rd_tr  <= transpose;
      end else if (w_issue && (r_rd_ptr != L_LAST)) begin
        if (!r_rd_tr) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end else if (r_rd_row == ROW_LAST) begin
          r_rd_row <= '0;
          r_rd_col <= r_rd_col + 1'b1;
          r_rd_ptr <= LW'(r_rd_col) + LW'(1);
        end else begin
          r_rd_row <= r_rd_row + 1'b1;
          r_rd_ptr <= r_rd_ptr + L_STEP;
        end
      end
      if (w_rd_done) r_rd_buf <= (r_rd_buf == BUF_LAST) ? '0 : r_rd_buf + 1'b1;
    end
  end

`ifdef FRAME_TAG_EN
  localparam int TAGW = (DATA_W < 8) ? DATA_W : 8;
  logic [7:0] r_tag;

  // Count completed read frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_tag <= '0;
    else if (w_rd_done) r_tag <= r_tag + 8'd1;
  end

  // Replace the first pixel of the frame with the zero-extended frame count.
  always_comb begin
    w_rd_pix = r_mem[w_rd_addr];
    if (r_rd_ptr == '0) begin
      w_rd_pix = '0;
      for (int i = 0; i < TAGW; i++) w_rd_pix[i] = r_tag[i];
    end
  end
`else
  assign w_rd_pix = r_mem[w_rd_addr];
`endif

  // Output register. It loads on issue and holds while the downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else if (w_issue) begin
      r_out_data  <= w_rd_pix;
      r_out_valid <= 1'b1;
      r_out_sof   <= (r_rd_ptr == '0);
      r_out_eof   <= (r_rd_ptr == L_LAST);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
    end
  end

  assign out_data       = r_out_data;
  assign out_valid      = r_out_valid;
  assign out_sof        = r_out_sof;
  assign out_eof        = r_out_eof;
  assign overflow       = r_overflow;
  assign frames_pending = r_pend;

endmodule

// File: tb/tb_frame_transpose_buffer.sv
// Bench for frame_transpose_buffer.
// Main instance: 4x3 frames, full band, 2 slots, RD_INTERVAL 2. A queue-based frame model checks every cycle.
// Second instance: 4x3 frames with a one-row band, for the centred-write case.
module tb_frame_transpose_buffer;
  localparam int W   = 4;
  localparam int H   = 3;
  localparam int DW  = 21;
  localparam int NB  = 2;
  localparam int RI  = 2;
  localparam int FR  = W * H;

  typedef logic [DW-1:0] pix_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  pix_t       in_data;
  logic       in_valid, transpose, out_ready;
  pix_t       out_data;
  logic       out_valid, out_sof, out_eof, overflow;
  logic [1:0] frames_pending;

  pix_t       b_in_data;
  logic       b_in_valid, b_transpose, b_out_ready;
  pix_t       b_out_data;
  logic       b_out_valid, b_out_sof, b_out_eof, b_overflow;
  logic [1:0] b_frames_pending;

  always #5 clk = ~clk;

  frame_transpose_buffer #(.WIDTH(W), .HEIGHT(H), .WR_HEIGHT(3), .DATA_W(DW),
                           .NUM_BUFS(NB), .RD_INTERVAL(RI)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .transpose(transpose), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
    .overflow(overflow), .frames_pending(frames_pending));

  frame_transpose_buffer #(.WIDTH(W), .HEIGHT(H), .WR_HEIGHT(1), .DATA_W(DW),
                           .NUM_BUFS(NB), .RD_INTERVAL(3)) u_band (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .transpose(b_transpose), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_sof(b_out_sof), .out_eof(b_out_eof),
    .overflow(b_overflow), .frames_pending(b_frames_pending));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model of the frame store: completed frames, in address order, queued back to back.
  pix_t pq[$];
  pix_t wf[$];
  bit   m_tr;
  int   idx;
  bit   exp_ovf;
  bit   prev_valid, prev_acc;
  int   cyc, last_new, dut_ovf_cnt;
  logic [7:0] tag;
  int   acc_log[$];
  int   new_cycs[$];
  int   nfr, a, gap;
  bit   rdone, drop, acc;
  pix_t e;

  pix_t b_log[$];
  bit   b_sof_q[$];
  bit   b_eof_q[$];

  function automatic int exp_addr(input int k, input bit tr);
    if (tr) return (k % H) * W + (k / H);
    return k;
  endfunction

  // Check the main instance against the model every cycle, then advance the model.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      pq.delete(); wf.delete();
      idx = 0; exp_ovf = 0; prev_valid = 0; prev_acc = 0; last_new = -1000; tag = '0;
    end else begin
      nfr = pq.size() / FR;
      chk("frames_pending", frames_pending, nfr);
      chk("overflow", overflow, exp_ovf);
      if (overflow) dut_ovf_cnt++;
      if (prev_valid && !prev_acc) chk("valid_held", out_valid, 1);
      acc   = out_valid && out_ready;
      rdone = 0;
      if (out_valid) begin
        if (nfr == 0) chk("spurious_out_valid", out_valid, 0);
        else begin
          a = exp_addr(idx, m_tr);
          e = pq[a];
`ifdef FRAME_TAG_EN
          if (idx == 0) e = pix_t'(tag);
`endif
          chk("out_data", out_data, e);
          chk("out_sof", out_sof, idx == 0);
          chk("out_eof", out_eof, idx == FR - 1);
        end
        if (!prev_valid || prev_acc) begin
          if (last_new > -1000) begin
            gap = cyc - last_new;
            n_checks++;
            if (gap < RI) begin
              n_fail++;
              $display("FAIL issue_gap: got %0d cycles, need at least %0d", gap, RI);
            end
          end
          last_new = cyc;
          new_cycs.push_back(cyc);
        end
      end
      if (acc) begin
        acc_log.push_back(int'(out_data));
        if (nfr > 0) begin
          if (idx == FR - 1) begin
            rdone = 1; idx = 0; tag = tag + 8'd1;
            repeat (FR) void'(pq.pop_front());
          end else idx++;
        end
      end
      drop = 0;
      if (in_valid) begin
        wf.push_back(in_data);
        if (wf.size() == FR) begin
          if (nfr < NB - 1 || rdone) foreach (wf[i]) pq.push_back(wf[i]);
          else drop = 1;
          wf.delete();
        end
      end
      exp_ovf    = drop;
      prev_valid = out_valid;
      prev_acc   = acc;
    end
  end

  // Record accepted pixels from the band instance.
  always @(negedge clk) begin
    if (!reset && b_out_valid && b_out_ready) begin
      b_log.push_back(b_out_data);
      b_sof_q.push_back(b_out_sof);
      b_eof_q.push_back(b_out_eof);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_pix(input pix_t d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic write_frame(input int base);
    for (int i = 0; i < FR; i++) push_pix(pix_t'(base + i));
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((pq.size() != 0 || out_valid) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_t[12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
    int bad, n;
    in_valid = 0; in_data = '0; transpose = 1; out_ready = 1; m_tr = 1;
    b_in_valid = 0; b_in_data = '0; b_transpose = 1; b_out_ready = 1;
    dut_ovf_cnt = 0; cyc = 0;
    reset = 1;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_eof", out_eof, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pending", frames_pending, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_band_pending", b_frames_pending, 0);
    reset = 0;
    step();

    // Phase 1: a column-major readout with an always-ready sink.
    acc_log.delete(); new_cycs.delete();
    write_frame(0);
    wait_drain(200);
    chk("p1_count", acc_log.size(), 12);
    for (int k = 0; k < 12 && k < acc_log.size(); k++) chk("p1_order", acc_log[k], exp_t[k]);
    bad = 0;
    for (int k = 1; k < new_cycs.size(); k++) if (new_cycs[k] - new_cycs[k-1] != RI) bad++;
    chk("p1_issue_spacing", bad, 0);

    // Phase 2: a row-major readout; pending count rises and then falls.
    transpose = 0; m_tr = 0; acc_log.delete();
    write_frame(0);
    chk("p2_pending_up", frames_pending, 1);
    wait_drain(200);
    chk("p2_pending_down", frames_pending, 0);
    chk("p2_count", acc_log.size(), 12);
    for (int k = 1; k < 12 && k < acc_log.size(); k++) chk("p2_order", acc_log[k], k);

    // Phase 3: the sink stalls for 5 cycles mid-frame.
    transpose = 1; m_tr = 1; acc_log.delete();
    write_frame(100);
    n = 0;
    while (acc_log.size() < 4 && n < 200) begin step(); n++; end
    if (n >= 200) chk("p3_timeout", 1, 0);
    out_ready = 0;
    repeat (5) step();
    out_ready = 1;
    wait_drain(200);
    chk("p3_count", acc_log.size(), 12);
    for (int k = 1; k < 12 && k < acc_log.size(); k++)
      chk("p3_order", acc_log[k], 100 + (k % 3) * 4 + k / 3);

    // Phase 4: back-to-back frames with no sink cause an overflow; the next frame reuses the slot.
    transpose = 0; m_tr = 0; acc_log.delete(); dut_ovf_cnt = 0;
    out_ready = 0;
    write_frame(200);
    write_frame(300);
    step();
    chk("p4_overflow_pulses", dut_ovf_cnt, 1);
    chk("p4_pending", frames_pending, 1);
    for (int i = 0; i < FR - 1; i++) push_pix(pix_t'(400 + i));
    out_ready = 1;
    wait_drain(200);
    push_pix(pix_t'(400 + FR - 1));
    wait_drain(200);
    chk("p4_count", acc_log.size(), 24);
    if (acc_log.size() == 24) begin
      chk("p4_f1_px1", acc_log[1], 201);
      chk("p4_f3_px1", acc_log[13], 401);
      chk("p4_f3_last", acc_log[23], 411);
    end
    chk("p4_overflow_total", dut_ovf_cnt, 1);

    // Phase 5: a one-row band is written to row 1 and read out transposed.
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1; b_in_data = pix_t'(10 + i);
      step();
    end
    b_in_valid = 0;
    n = 0;
    while ((b_log.size() < 12 || b_out_valid) && n < 300) begin step(); n++; end
    chk("p5_count", b_log.size(), 12);
    if (b_log.size() == 12) begin
      chk("p5_pos1", b_log[1], 10);
      chk("p5_pos4", b_log[4], 11);
      chk("p5_pos7", b_log[7], 12);
      chk("p5_pos10", b_log[10], 13);
      chk("p5_sof", b_sof_q[0], 1);
      chk("p5_eof", b_eof_q[11], 1);
    end
    chk("p5_pending", b_frames_pending, 0);
    chk("p5_overflow", b_overflow, 0);

    // Phase 6: random input gaps, random sink stalls and a random order per round.
    for (int ph = 0; ph < 6; ph++) begin
      transpose = 1'($urandom_range(0, 1)); m_tr = transpose;
      repeat (200) begin
        in_valid  = ($urandom_range(0, 9) < 6);
        in_data   = pix_t'($urandom);
        out_ready = ($urandom_range(0, 9) < 7);
        step();
      end
      in_valid = 0; out_ready = 1;
      while (wf.size() != 0) push_pix(pix_t'($urandom));
      wait_drain(500);
    end

    // Phase 7: reset during a stalled readout and a partial write, then fresh frames.
    transpose = 1; m_tr = 1; out_ready = 0;
    write_frame(500);
    for (int i = 0; i < 5; i++) push_pix(pix_t'(600 + i));
    chk("p7_pending_before", frames_pending, 1);
    chk("p7_valid_before", out_valid, 1);
    reset = 1;
    #1;
    chk("p7_rst_valid", out_valid, 0);
    chk("p7_rst_pending", frames_pending, 0);
    chk("p7_rst_overflow", overflow, 0);
    step(); step();
    reset = 0; out_ready = 1; acc_log.delete();
    step();
    write_frame(700);
    wait_drain(200);
    write_frame(800);
    wait_drain(200);
    chk("p7_count", acc_log.size(), 24);
    if (acc_log.size() == 24) begin
`ifdef FRAME_TAG_EN
      chk("p7_f0_first", acc_log[0], 0);
      chk("p7_f1_first", acc_log[12], 1);
`else
      chk("p7_f0_first", acc_log[0], 700);
      chk("p7_f1_first", acc_log[12], 800);
`endif
      chk("p7_f0_px1", acc_log[1], 704);
      chk("p7_f1_px1", acc_log[13], 804);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
